// File: rtl/multicycle_main_fsm.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake, traps on illegal opcodes and memory-wait timeouts.
module multicycle_main_fsm #(
  parameter int STALL_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter bit ENABLE_UPPER    = 1'b1
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic [6:0]                 i_OpCode,
  input  logic [2:0]                 i_Funct3,
  input  logic                       i_ZeroFlag,
  input  logic                       i_MemReady,
  output logic                       o_PcWrite,
  output logic                       o_AdrSrc,
  output logic                       o_IrWrite,
  output logic                       o_MemRead,
  output logic                       o_MemWrite,
  output logic                       o_RegWrite,
  output logic [1:0]                 o_ResultSrc,
  output logic [1:0]                 o_AluSrcA,
  output logic [1:0]                 o_AluSrcB,
  output logic [1:0]                 o_AluOp,
  output logic [2:0]                 o_ImmSrc,
  output logic                       o_IllegalInstr,
  output logic                       o_MemTimeout,
  output logic [3:0]                 o_State,
  output logic [STALL_CNT_WIDTH-1:0] o_StallCount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_UPPER    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                     state, state_next;
  logic [TIMEOUT_WIDTH-1:0]   wait_cnt;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;
  logic                       illegal_flag, timeout_flag;
  logic                       stalled, timeout_hit;

  // A wait state without ready is a stall; the last allowed stall cycle becomes a timeout.
  assign stalled     = (state inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !i_MemReady;
  assign timeout_hit = TIMEOUT_EN && stalled && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (i_MemReady)       state_next = S_DECODE;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_DECODE: begin
        case (i_OpCode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = (i_Funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = (i_Funct3 == 3'b000) ? S_JALR : S_TRAP;
          OP_LUI, OP_AUIPC:  state_next = ENABLE_UPPER ? S_UPPER : S_TRAP;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = i_OpCode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (i_MemReady)       state_next = S_MEMWB;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: begin
        if (i_MemReady)       state_next = S_FETCH;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_EXECR, S_EXECI, S_JAL, S_UPPER: state_next = S_ALUWB;
      S_ALUWB, S_BRANCH, S_LINK:        state_next = S_FETCH;
      S_JALR:     state_next = S_LINK;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wait_cnt     <= '0;
      stall_cnt    <= '0;
      illegal_flag <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (state_next != state) wait_cnt <= '0;
      else if (stalled)        wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
      if (stalled && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
      if (state == S_DECODE && state_next == S_TRAP) illegal_flag <= 1'b1;
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end

  always_comb begin
    o_PcWrite   = 1'b0;
    o_AdrSrc    = 1'b0;
    o_IrWrite   = 1'b0;
    o_MemRead   = 1'b0;
    o_MemWrite  = 1'b0;
    o_RegWrite  = 1'b0;
    o_ResultSrc = 2'b00;
    o_AluSrcA   = 2'b00;
    o_AluSrcB   = 2'b00;
    o_AluOp     = 2'b00;
    o_ImmSrc    = 3'b000;
    case (state)
      S_FETCH: begin
        o_MemRead   = 1'b1;
        o_AluSrcB   = 2'b10;
        o_ResultSrc = 2'b10;
        o_IrWrite   = i_MemReady;
        o_PcWrite   = i_MemReady;
      end
      S_DECODE: begin
        o_AluSrcA = 2'b01;
        o_AluSrcB = 2'b01;
        o_ImmSrc  = 3'b010;
      end
      S_MEMADR: begin
        o_AluSrcA = 2'b10;
        o_AluSrcB = 2'b01;
        o_ImmSrc  = i_OpCode[5] ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        o_AdrSrc  = 1'b1;
        o_MemRead = 1'b1;
      end
      S_MEMWB: begin
        o_ResultSrc = 2'b01;
        o_RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        o_AdrSrc   = 1'b1;
        o_MemWrite = 1'b1;
      end
      S_EXECR: begin
        o_AluSrcA = 2'b10;
        o_AluOp   = 2'b10;
      end
      S_EXECI: begin
        o_AluSrcA = 2'b10;
        o_AluSrcB = 2'b01;
        o_AluOp   = 2'b10;
      end
      S_ALUWB: o_RegWrite = 1'b1;
      S_BRANCH: begin
        o_AluSrcA = 2'b10;
        o_AluOp   = 2'b01;
        o_PcWrite = i_ZeroFlag ^ i_Funct3[0];
      end
      S_JAL: begin
        o_AluSrcA = 2'b01;
        o_AluSrcB = 2'b10;
        o_PcWrite = 1'b1;
      end
      S_JALR: begin
        o_AluSrcA   = 2'b10;
        o_AluSrcB   = 2'b01;
        o_ResultSrc = 2'b10;
        o_PcWrite   = 1'b1;
      end
      S_LINK: begin
        o_AluSrcA   = 2'b01;
        o_AluSrcB   = 2'b10;
        o_ResultSrc = 2'b10;
        o_RegWrite  = 1'b1;
      end
      S_UPPER: begin
        o_ImmSrc  = 3'b100;
        o_AluSrcB = 2'b01;
        o_AluSrcA = i_OpCode[5] ? 2'b11 : 2'b01;
      end
      default: ;
    endcase
    // Reset kills every strobe in the same cycle so an abandoned access never writes.
    if (i_Rst) begin
      o_PcWrite  = 1'b0;
      o_IrWrite  = 1'b0;
      o_MemRead  = 1'b0;
      o_MemWrite = 1'b0;
      o_RegWrite = 1'b0;
    end
  end

  assign o_State        = state;
  assign o_StallCount   = stall_cnt;
  assign o_IllegalInstr = illegal_flag;
  assign o_MemTimeout   = timeout_flag;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: directed scenarios plus randomized instruction streams
// checked against a per-instruction state-path model.
module tb_multicycle_main_fsm;
  localparam int SCW = 4;
  localparam int TO  = 4;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
    S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11, S_LINK = 4'd12, S_UPPER = 4'd13, S_TRAP = 4'd14;

  logic i_Clk = 1'b0, i_Rst = 1'b1;
  logic [6:0] i_OpCode = '0;
  logic [2:0] i_Funct3 = '0;
  logic i_ZeroFlag = 1'b0, i_MemReady = 1'b0;
  logic o_PcWrite, o_AdrSrc, o_IrWrite, o_MemRead, o_MemWrite, o_RegWrite;
  logic [1:0] o_ResultSrc, o_AluSrcA, o_AluSrcB, o_AluOp;
  logic [2:0] o_ImmSrc;
  logic o_IllegalInstr, o_MemTimeout;
  logic [3:0] o_State;
  logic [SCW-1:0] o_StallCount;
  logic [16:0] ctrl;
  logic [4:0] strobes;

  int n_checks = 0, n_pass = 0;
  logic [3:0] exp_q[$];
  int m_stall, m_waited;
  bit m_illegal, m_timeout;

  always #5 i_Clk = ~i_Clk;

  multicycle_main_fsm #(.STALL_CNT_WIDTH(SCW), .TIMEOUT_WIDTH(8), .TIMEOUT_CYCLES(TO), .ENABLE_UPPER(1'b1)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_OpCode(i_OpCode), .i_Funct3(i_Funct3), .i_ZeroFlag(i_ZeroFlag),
    .i_MemReady(i_MemReady), .o_PcWrite(o_PcWrite), .o_AdrSrc(o_AdrSrc), .o_IrWrite(o_IrWrite),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_RegWrite(o_RegWrite), .o_ResultSrc(o_ResultSrc),
    .o_AluSrcA(o_AluSrcA), .o_AluSrcB(o_AluSrcB), .o_AluOp(o_AluOp), .o_ImmSrc(o_ImmSrc),
    .o_IllegalInstr(o_IllegalInstr), .o_MemTimeout(o_MemTimeout), .o_State(o_State),
    .o_StallCount(o_StallCount)
  );

  assign ctrl = {o_PcWrite, o_AdrSrc, o_IrWrite, o_MemRead, o_MemWrite, o_RegWrite,
                 o_ResultSrc, o_AluSrcA, o_AluSrcB, o_AluOp, o_ImmSrc};
  assign strobes = {o_PcWrite, o_IrWrite, o_MemRead, o_MemWrite, o_RegWrite};

  // Control word required in each named step of an instruction.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic [6:0] op,
                                           input logic [2:0] f3, input logic z, input logic rdy);
    logic pc, adr, ir, mr, mw, rw;
    logic [1:0] rs, sa, sb, ao;
    logic [2:0] im;
    {pc, adr, ir, mr, mw, rw} = 6'b0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00; im = 3'b000;
    case (st)
      S_FETCH:    begin mr = 1; sb = 2'b10; rs = 2'b10; ir = rdy; pc = rdy; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; im = 3'b010; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; im = (op == 7'b0100011) ? 3'b001 : 3'b000; end
      S_MEMREAD:  begin adr = 1; mr = 1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECR:    begin sa = 2'b10; ao = 2'b10; end
      S_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      S_ALUWB:    rw = 1;
      S_BRANCH:   begin sa = 2'b10; ao = 2'b01; pc = (f3 == 3'b000) ? z : !z; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; pc = 1; end
      S_JALR:     begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pc = 1; end
      S_LINK:     begin sa = 2'b01; sb = 2'b10; rs = 2'b10; rw = 1; end
      S_UPPER:    begin im = 3'b100; sb = 2'b01; sa = (op == 7'b0110111) ? 2'b11 : 2'b01; end
      default:    ;
    endcase
    return {pc, adr, ir, mr, mw, rw, rs, sa, sb, ao, im};
  endfunction

  // Path of steps an instruction takes when memory is always ready.
  function automatic void build_plan(input logic [6:0] op, input logic [2:0] f3);
    exp_q = {S_FETCH, S_DECODE};
    case (op)
      7'b0000011: exp_q = {exp_q, S_MEMADR, S_MEMREAD, S_MEMWB};
      7'b0100011: exp_q = {exp_q, S_MEMADR, S_MEMWRITE};
      7'b0110011: exp_q = {exp_q, S_EXECR, S_ALUWB};
      7'b0010011: exp_q = {exp_q, S_EXECI, S_ALUWB};
      7'b1100011: exp_q = {exp_q, (f3 < 3'd2) ? S_BRANCH : S_TRAP};
      7'b1101111: exp_q = {exp_q, S_JAL, S_ALUWB};
      7'b1100111: exp_q = {exp_q, (f3 == 3'd0) ? S_JALR : S_TRAP};
      7'b0110111, 7'b0010111: exp_q = {exp_q, S_UPPER, S_ALUWB};
      default:    exp_q = {exp_q, S_TRAP};
    endcase
    if (op == 7'b1100111 && f3 == 3'd0) exp_q = {exp_q, S_LINK};
  endfunction

  task automatic cyc(input logic rdy, input logic z);
    @(negedge i_Clk);
    i_MemReady = rdy;
    i_ZeroFlag = z;
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    i_Rst = 1'b1;
    i_MemReady = 1'b0;
    @(posedge i_Clk);
    #1 i_Rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_Clk);
    i_Rst = 1'b1; i_MemReady = 1'b1;
    #1;
    n_checks++; if (strobes !== 5'b0) $display("FAIL reset_strobes got=%b exp=00000", strobes); else n_pass++;
    @(posedge i_Clk);
    #1 i_Rst = 1'b0;
    cyc(0, 0);
    n_checks++; if (o_State !== S_FETCH) $display("FAIL reset_state got=%0d exp=0", o_State); else n_pass++;
    n_checks++; if (o_StallCount !== '0) $display("FAIL reset_stall got=%0d exp=0", o_StallCount); else n_pass++;
    n_checks++; if ({o_IllegalInstr, o_MemTimeout} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {o_IllegalInstr, o_MemTimeout}); else n_pass++;
  endtask

  task automatic test_add();
    logic [3:0] path [5];
    path = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
    do_reset();
    i_OpCode = 7'b0110011; i_Funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      cyc(i < 4, 0);
      n_checks++; if (o_State !== path[i]) $display("FAIL add_state step=%0d got=%0d exp=%0d", i, o_State, path[i]); else n_pass++;
      n_checks++; if (o_RegWrite !== (i == 3)) $display("FAIL add_regwrite step=%0d got=%b exp=%b", i, o_RegWrite, i == 3); else n_pass++;
    end
    n_checks++; if (o_StallCount !== '0) $display("FAIL add_stall got=%0d exp=0", o_StallCount); else n_pass++;
  endtask

  task automatic test_lw_wait();
    do_reset();
    i_OpCode = 7'b0000011; i_Funct3 = 3'b010;
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    n_checks++; if (o_ImmSrc !== 3'b000) $display("FAIL lw_immsrc got=%b exp=000", o_ImmSrc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, 0);
      n_checks++; if ({o_State, o_MemRead, o_AdrSrc} !== {S_MEMREAD, 2'b11}) $display("FAIL lw_memread step=%0d got=%0d/%b exp=3/11", i, o_State, {o_MemRead, o_AdrSrc}); else n_pass++;
    end
    cyc(1, 0);
    n_checks++; if ({o_State, o_RegWrite, o_ResultSrc} !== {S_MEMWB, 3'b101}) $display("FAIL lw_memwb got=%0d/%b exp=4/101", o_State, {o_RegWrite, o_ResultSrc}); else n_pass++;
    n_checks++; if (o_StallCount !== SCW'(3)) $display("FAIL lw_stall got=%0d exp=3", o_StallCount); else n_pass++;
    n_checks++; if (o_MemTimeout !== 1'b0) $display("FAIL lw_timeout got=%b exp=0", o_MemTimeout); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    i_OpCode = 7'b1100011; i_Funct3 = 3'b000;
    cyc(1, 0); cyc(1, 0); cyc(1, 1);
    n_checks++; if ({o_State, o_PcWrite} !== {S_BRANCH, 1'b1}) $display("FAIL beq_taken got=%0d/%b exp=9/1", o_State, o_PcWrite); else n_pass++;
    i_Funct3 = 3'b001;
    cyc(1, 0); cyc(1, 0); cyc(1, 1);
    n_checks++; if ({o_State, o_PcWrite} !== {S_BRANCH, 1'b0}) $display("FAIL bne_not_taken got=%0d/%b exp=9/0", o_State, o_PcWrite); else n_pass++;
    i_Funct3 = 3'b100;
    cyc(1, 0); cyc(1, 0); cyc(1, 1);
    n_checks++; if ({o_State, o_IllegalInstr} !== {S_TRAP, 1'b1}) $display("FAIL branch_trap got=%0d/%b exp=14/1", o_State, o_IllegalInstr); else n_pass++;
    n_checks++; if (strobes !== 5'b0) $display("FAIL trap_strobes got=%b exp=00000", strobes); else n_pass++;
  endtask

  task automatic test_jalr();
    do_reset();
    i_OpCode = 7'b1100111; i_Funct3 = 3'b000;
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    n_checks++; if ({o_State, o_PcWrite, o_ResultSrc} !== {S_JALR, 3'b110}) $display("FAIL jalr_step got=%0d/%b exp=11/110", o_State, {o_PcWrite, o_ResultSrc}); else n_pass++;
    cyc(1, 0);
    n_checks++; if ({o_State, o_RegWrite, o_AluSrcA, o_AluSrcB} !== {S_LINK, 5'b10110}) $display("FAIL jalr_link got=%0d/%b exp=12/10110", o_State, {o_RegWrite, o_AluSrcA, o_AluSrcB}); else n_pass++;
    cyc(1, 0);
    n_checks++; if (o_State !== S_FETCH) $display("FAIL jalr_return got=%0d exp=0", o_State); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TO; i++) begin
      cyc(0, 0);
      n_checks++; if ({o_State, o_MemRead, o_MemTimeout} !== {S_FETCH, 2'b10}) $display("FAIL to_wait step=%0d got=%0d/%b exp=0/10", i, o_State, {o_MemRead, o_MemTimeout}); else n_pass++;
    end
    cyc(1, 0);
    n_checks++; if ({o_State, o_MemTimeout} !== {S_TRAP, 1'b1}) $display("FAIL to_trap got=%0d/%b exp=14/1", o_State, o_MemTimeout); else n_pass++;
    n_checks++; if (strobes !== 5'b0) $display("FAIL to_strobes got=%b exp=00000", strobes); else n_pass++;
    n_checks++; if (o_StallCount !== SCW'(TO)) $display("FAIL to_stall got=%0d exp=%0d", o_StallCount, TO); else n_pass++;
  endtask

  task automatic test_rst_memwrite();
    do_reset();
    i_OpCode = 7'b0100011; i_Funct3 = 3'b010;
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    n_checks++; if (o_ImmSrc !== 3'b001) $display("FAIL sw_immsrc got=%b exp=001", o_ImmSrc); else n_pass++;
    cyc(0, 0); cyc(0, 0);
    n_checks++; if ({o_State, o_MemWrite, o_AdrSrc} !== {S_MEMWRITE, 2'b11}) $display("FAIL sw_wait got=%0d/%b exp=5/11", o_State, {o_MemWrite, o_AdrSrc}); else n_pass++;
    @(negedge i_Clk);
    i_Rst = 1'b1; i_MemReady = 1'b0;
    #1;
    n_checks++; if (o_MemWrite !== 1'b0) $display("FAIL sw_rst_memwrite got=%b exp=0", o_MemWrite); else n_pass++;
    @(posedge i_Clk);
    #1 i_Rst = 1'b0;
    cyc(0, 0);
    n_checks++; if ({o_State, o_StallCount, o_IllegalInstr, o_MemTimeout} !== {S_FETCH, SCW'(0), 2'b00}) $display("FAIL sw_rst_after got=%0d/%0d/%b exp=0/0/00", o_State, o_StallCount, {o_IllegalInstr, o_MemTimeout}); else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] st;
    logic rdy, z;
    logic [16:0] want;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1100011};
    do_reset();
    m_stall = 0; m_illegal = 0; m_timeout = 0;
    st = S_FETCH;
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      f3 = 3'($urandom_range(0, 7));
      i_OpCode = op; i_Funct3 = f3;
      build_plan(op, f3);
      m_waited = 0;
      while (exp_q.size() > 0) begin
        st = exp_q[0];
        rdy = ($urandom_range(0, 9) < 6);
        z = 1'($urandom_range(0, 1));
        cyc(rdy, z);
        want = exp_ctrl(st, op, f3, z, rdy);
        n_checks++; if (o_State !== st) $display("FAIL rnd_state n=%0d op=%b got=%0d exp=%0d", n, op, o_State, st); else n_pass++;
        n_checks++; if (ctrl !== want) $display("FAIL rnd_ctrl n=%0d st=%0d got=%h exp=%h", n, st, ctrl, want); else n_pass++;
        n_checks++; if (o_StallCount !== SCW'(m_stall)) $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, o_StallCount, m_stall); else n_pass++;
        n_checks++; if ({o_IllegalInstr, o_MemTimeout} !== {m_illegal, m_timeout}) $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {o_IllegalInstr, o_MemTimeout}, {m_illegal, m_timeout}); else n_pass++;
        @(posedge i_Clk);
        if ((st == S_FETCH || st == S_MEMREAD || st == S_MEMWRITE) && !rdy) begin
          if (m_stall < (1 << SCW) - 1) m_stall++;
          m_waited++;
          if (m_waited == TO) begin
            m_timeout = 1;
            exp_q = {S_TRAP};
          end
        end else if (st == S_TRAP) begin
          exp_q.delete();
        end else begin
          m_waited = 0;
          if (st == S_DECODE && exp_q[1] == S_TRAP) m_illegal = 1;
          void'(exp_q.pop_front());
        end
      end
      if (st == S_TRAP) begin
        do_reset();
        m_stall = 0; m_illegal = 0; m_timeout = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jalr();
    test_timeout();
    test_rst_memwrite();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
